// File: rtl/varint_pkg.sv
// Shared types and constants for the varint encoder arbiter.
package varint_pkg;

  localparam int DATA_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  // Width of a source index; never below one bit.
  function automatic int id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/varint_tag_fifo.sv
// Synchronous FIFO holding the source id of every message handed to the encoder.
module varint_tag_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  input  logic                     clr,
  output logic [W-1:0]             pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full && !clr;
  assign do_pop   = pop && !empty && !clr;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/varint_enc_arbiter.sv
// Round-robin message arbiter in front of the shared varint encoder; remembers
// which source owns each in-flight message and reports it on completion.
module varint_enc_arbiter
  import varint_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = varint_pkg::DATA_W,
  parameter int MAX_OUT = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_last,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        varint_in_fifo_full,
  output logic                        varint_in_fifo_push,
  output logic [DATA_W-1:0]           varint_in_fifo_data,
  output logic                        varint_in_index_push,
  input  logic                        varint_out_index_push,
  input  logic                        flush,
  output logic                        done_valid,
  output logic [id_w(NUM_REQ)-1:0]    done_id,
  output logic                        busy,
  output logic                        err_underflow,
  output arb_state_e                  dbg_state
);

  // Handshake: a word moves when req_valid[i] and req_ready[i] are both high at
  // the rising edge; ready only ever rises for the granted source while in XFER.

  localparam int ID_W  = id_w(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_OUT) + 1;

  arb_state_e        state;
  logic [ID_W-1:0]   grant;
  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   pick;
  logic [NUM_REQ-1:0] prio_mask;
  logic [NUM_REQ-1:0] masked;
  logic              active;
  logic              xfer;
  logic              tag_pop;
  logic [ID_W-1:0]   tag_head;
  logic              tag_full;
  logic              tag_empty;
  logic [CNT_W-1:0]  tag_count;

  function automatic logic [ID_W-1:0] lowest(input logic [NUM_REQ-1:0] v);
    lowest = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (v[i]) lowest = ID_W'(i);
    end
  endfunction

  // Sources above the last winner get first pick; otherwise wrap to the lowest.
  always_comb begin
    prio_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) prio_mask[i] = (i > int'(last_grant));
    masked = req_valid & prio_mask;
    pick   = (masked != '0) ? lowest(masked) : lowest(req_valid);
  end

  assign active = (state == XFER) && !flush;

  always_comb begin
    req_ready = '0;
    if (active && !varint_in_fifo_full) req_ready[grant] = 1'b1;
  end

  assign xfer                 = req_valid[grant] & req_ready[grant];
  assign varint_in_fifo_push  = xfer;
  assign varint_in_fifo_data  = xfer ? req_data[int'(grant)*DATA_W +: DATA_W] : '0;
  assign varint_in_index_push = xfer & req_last[grant];
  assign tag_pop              = varint_out_index_push & !flush & !tag_empty;
  assign busy                 = (state == XFER) | (tag_count != '0);
  assign dbg_state            = state;

  varint_tag_fifo #(
    .W     (ID_W),
    .DEPTH (MAX_OUT)
  ) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (varint_in_index_push),
    .push_data (grant),
    .pop       (tag_pop),
    .clr       (flush),
    .pop_data  (tag_head),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (tag_count)
  );

  // Granting only while the tag FIFO has room reserves the slot the message will use.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      grant         <= '0;
      last_grant    <= ID_W'(NUM_REQ - 1);
      done_valid    <= 1'b0;
      done_id       <= '0;
      err_underflow <= 1'b0;
    end else begin
      done_valid <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else begin
        if (varint_out_index_push) begin
          if (tag_empty) begin
            err_underflow <= 1'b1;
          end else begin
            done_valid <= 1'b1;
            done_id    <= tag_head;
          end
        end
        case (state)
          IDLE: begin
            if ((|req_valid) && !tag_full) begin
              grant <= pick;
              state <= XFER;
            end
          end
          XFER: begin
            if (varint_in_index_push) begin
              last_grant <= grant;
              state      <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_varint_enc_arbiter.sv
// Randomized scoreboard bench for varint_enc_arbiter with a message-level round-robin model.
module tb_varint_enc_arbiter;
  import varint_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int DW      = 32;
  localparam int MAX_OUT = 8;
  localparam int ID_W    = 2;

  logic                    clk;
  logic                    reset;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_last;
  logic [NUM_REQ*DW-1:0]   req_data;
  logic [NUM_REQ-1:0]      req_ready;
  logic                    varint_in_fifo_full;
  logic                    varint_in_fifo_push;
  logic [DW-1:0]           varint_in_fifo_data;
  logic                    varint_in_index_push;
  logic                    varint_out_index_push;
  logic                    flush;
  logic                    done_valid;
  logic [ID_W-1:0]         done_id;
  logic                    busy;
  logic                    err_underflow;
  arb_state_e              dbg_state;

  varint_enc_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DW), .MAX_OUT(MAX_OUT)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .req_valid             (req_valid),
    .req_last              (req_last),
    .req_data              (req_data),
    .req_ready             (req_ready),
    .varint_in_fifo_full   (varint_in_fifo_full),
    .varint_in_fifo_push   (varint_in_fifo_push),
    .varint_in_fifo_data   (varint_in_fifo_data),
    .varint_in_index_push  (varint_in_index_push),
    .varint_out_index_push (varint_out_index_push),
    .flush                 (flush),
    .done_valid            (done_valid),
    .done_id               (done_id),
    .busy                  (busy),
    .err_underflow         (err_underflow),
    .dbg_state             (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [DW:0]     exp_word_q[$];
  logic [ID_W-1:0] exp_tag_q[$];
  logic [DW:0]     src_q[NUM_REQ][$];
  logic [DW:0]     mdl_q[NUM_REQ][$];
  int              push_cyc_q[$];
  int  n_vec = 0;
  int  n_err = 0;
  int  words_pushed = 0;
  int  idx_pushed = 0;
  int  inflight = 0;
  bit  exp_done = 1'b0;
  int  model_last = NUM_REQ - 1;
  bit  gaps_en = 1'b0;
  bit  pop_en = 1'b0;
  bit  force_pop = 1'b0;
  int  full_mode = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int src_pending();
    int total = 0;
    for (int s = 0; s < NUM_REQ; s++) total += src_q[s].size();
    return total;
  endfunction

  // Append one message (n words, last flag on the final word) for source s.
  task automatic load_msg(input int s, input int n);
    logic [DW:0] it;
    for (int k = 0; k < n; k++) begin
      it = {k == n - 1, $urandom()};
      src_q[s].push_back(it);
      mdl_q[s].push_back(it);
    end
  endtask

  // Reference: whole messages granted round-robin among sources with work pending.
  task automatic plan();
    int last;
    int s;
    bit any;
    logic [DW:0] it;
    last = model_last;
    do begin
      any = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
        s = (last + k) % NUM_REQ;
        if (!any && mdl_q[s].size() > 0) begin
          any = 1'b1;
          last = s;
          exp_tag_q.push_back(ID_W'(s));
          do begin
            it = mdl_q[s].pop_front();
            exp_word_q.push_back(it);
          end while (!it[DW]);
        end
      end
    end while (any);
    model_last = last;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_word_q.size() > 0 || src_pending() > 0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk({name, "_drain_timeout"}, 64'(n >= 3000), 64'(0));
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    pop_en = 1'b1;
    while ((exp_tag_q.size() > 0 || inflight > 0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    pop_en = 1'b0;
    chk({name, "_done_timeout"}, 64'(n >= 3000), 64'(0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({name, "_busy_idle"}, 64'(busy), 64'(0));
  endtask

  task automatic pulse_pop();
    @(posedge clk); #2;
    force_pop = 1'b1;
    @(posedge clk); #2;
    force_pop = 1'b0;
  endtask

  // ---------------- drivers ----------------
  initial begin
    bit took [NUM_REQ];
    bit mid [NUM_REQ];
    logic [DW:0] item;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    for (int s = 0; s < NUM_REQ; s++) mid[s] = 1'b0;
    forever begin
      @(negedge clk);
      for (int s = 0; s < NUM_REQ; s++) took[s] = req_valid[s] && req_ready[s] && !reset;
      @(posedge clk); #1;
      for (int s = 0; s < NUM_REQ; s++) begin
        if (reset) begin
          mid[s] = 1'b0;
          req_valid[s] = 1'b0;
          req_last[s] = 1'b0;
        end else begin
          if (took[s] && src_q[s].size() > 0) begin
            item = src_q[s].pop_front();
            mid[s] = !item[DW];
          end
          if (src_q[s].size() == 0) mid[s] = 1'b0;
          if (src_q[s].size() > 0 && !(mid[s] && gaps_en && $urandom_range(0, 3) == 0)) begin
            req_valid[s] = 1'b1;
            req_data[s*DW +: DW] = src_q[s][0][DW-1:0];
            req_last[s] = src_q[s][0][DW];
          end else begin
            req_valid[s] = 1'b0;
            req_last[s] = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    varint_in_fifo_full = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (full_mode)
        1:       varint_in_fifo_full = ($urandom_range(0, 3) == 0);
        2:       varint_in_fifo_full = 1'b1;
        default: varint_in_fifo_full = 1'b0;
      endcase
    end
  end

  initial begin
    varint_out_index_push = 1'b0;
    forever begin
      @(posedge clk); #1;
      varint_out_index_push = force_pop || (pop_en && inflight > 0 && $urandom_range(0, 2) == 0);
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [DW:0] w;
    logic [ID_W-1:0] t;
    forever begin
      @(negedge clk);
      if (reset) begin
        inflight = 0;
        exp_done = 1'b0;
      end else begin
        chk("done_valid", 64'(done_valid), 64'(exp_done));
        if (done_valid && exp_done) begin
          if (exp_tag_q.size() == 0) chk("done_unexpected", 64'(1), 64'(0));
          else begin
            t = exp_tag_q.pop_front();
            chk("done_id", 64'(done_id), 64'(t));
          end
        end
        if (varint_in_fifo_full || flush)
          chk("stall_quiet", 64'({varint_in_fifo_push, req_ready}), 64'(0));
        if (varint_in_fifo_push) begin
          if (exp_word_q.size() == 0) chk("push_unexpected", 64'(1), 64'(0));
          else begin
            w = exp_word_q.pop_front();
            chk("push_data", 64'(varint_in_fifo_data), 64'(w[DW-1:0]));
            chk("index_push", 64'(varint_in_index_push), 64'(w[DW]));
          end
          words_pushed++;
          push_cyc_q.push_back(cyc);
        end else begin
          chk("index_push_idle", 64'(varint_in_index_push), 64'(0));
        end
        if (varint_in_index_push) idx_pushed++;
        if (flush) begin
          inflight = 0;
          exp_done = 1'b0;
        end else begin
          exp_done = varint_out_index_push && inflight > 0;
          inflight = inflight + int'(varint_in_index_push) - int'(exp_done);
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int w0;
    int i0;
    int n;
    int saved_last;
    reset = 1'b1;
    flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 64'({varint_in_fifo_push, req_ready, varint_in_index_push, done_valid,
        done_id, busy, err_underflow, varint_in_fifo_data}), 64'(0));
    chk("reset_state", 64'(dbg_state), 64'(IDLE));
    reset = 1'b0;

    // Four sources, one-word messages, source 0 twice: order 0,1,2,3,0.
    @(posedge clk); #2;
    push_cyc_q.delete();
    for (int s = 0; s < NUM_REQ; s++) load_msg(s, 1);
    load_msg(0, 1);
    plan();
    wait_drain("rr_order");
    chk("rr_push_count", 64'(push_cyc_q.size()), 64'(5));
    for (int i = 1; i < push_cyc_q.size(); i++)
      chk("rr_grant_spacing", 64'(push_cyc_q[i] - push_cyc_q[i-1]), 64'(2));
    wait_done("rr_order");

    // Three-word message from source 0.
    @(posedge clk); #2;
    load_msg(0, 3);
    plan();
    wait_drain("msg3");
    @(negedge clk);
    chk("msg3_busy_tag", 64'(busy), 64'(1));
    wait_done("msg3");

    // Encoder FIFO full for five cycles in the middle of a message.
    @(posedge clk); #2;
    w0 = words_pushed;
    load_msg(1, 4);
    plan();
    n = 0;
    while (words_pushed < w0 + 1 && n < 100) begin @(posedge clk); n++; end
    #2 full_mode = 2;
    n = 0;
    do begin @(negedge clk); n++; end while (!varint_in_fifo_full && n < 20);
    w0 = words_pushed;
    repeat (5) begin
      @(negedge clk);
      chk("full_ready", 64'(req_ready), 64'(0));
    end
    chk("full_no_push", 64'(words_pushed), 64'(w0));
    full_mode = 0;
    wait_drain("full_stall");
    wait_done("full_stall");

    // Nine messages with no completions: eight tags fit, the ninth waits.
    @(posedge clk); #2;
    i0 = idx_pushed;
    load_msg(0, 1); load_msg(0, 1); load_msg(0, 1);
    load_msg(1, 1); load_msg(1, 1);
    load_msg(2, 1); load_msg(2, 1);
    load_msg(3, 1); load_msg(3, 1);
    plan();
    repeat (60) @(posedge clk);
    @(negedge clk);
    chk("tagfull_accepted", 64'(idx_pushed - i0), 64'(MAX_OUT));
    chk("tagfull_left", 64'(src_pending()), 64'(1));
    chk("tagfull_state", 64'(dbg_state), 64'(IDLE));
    chk("tagfull_ready", 64'(req_ready), 64'(0));
    pulse_pop();
    repeat (10) @(posedge clk);
    chk("tagfull_resume", 64'(idx_pushed - i0), 64'(MAX_OUT + 1));
    wait_drain("tagfull");
    wait_done("tagfull");

    // Randomized traffic: gaps, encoder back-pressure, random completions.
    for (int r = 0; r < 20; r++) begin
      @(posedge clk); #2;
      gaps_en = 1'b1;
      full_mode = 1;
      pop_en = 1'b1;
      for (int s = 0; s < NUM_REQ; s++)
        for (int m = $urandom_range(0, 2); m > 0; m--) load_msg(s, $urandom_range(1, 4));
      plan();
      wait_drain("random");
      full_mode = 0;
      gaps_en = 1'b0;
      wait_done("random");
    end

    // Flush after two words of a four-word message, with one tag in flight.
    @(posedge clk); #2;
    load_msg(3, 1);
    plan();
    wait_drain("pre_flush");
    @(negedge clk);
    chk("pre_flush_busy", 64'(busy), 64'(1));
    saved_last = model_last;
    @(posedge clk); #2;
    w0 = words_pushed;
    load_msg(2, 4);
    plan();
    n = 0;
    while (words_pushed < w0 + 2 && n < 100) begin @(posedge clk); n++; end
    #2 flush = 1'b1;
    src_q[2].delete();
    exp_word_q.delete();
    exp_tag_q.delete();
    model_last = saved_last;
    @(negedge clk);
    chk("flush_cycle_push", 64'(varint_in_fifo_push), 64'(0));
    @(posedge clk); #2;
    flush = 1'b0;
    repeat (10) @(negedge clk);
    chk("flush_busy", 64'(busy), 64'(0));
    chk("flush_no_more_push", 64'(words_pushed), 64'(w0 + 2));
    chk("flush_state", 64'(dbg_state), 64'(IDLE));

    // Completion with no tag in flight.
    chk("underflow_clear", 64'(err_underflow), 64'(0));
    pulse_pop();
    repeat (3) @(negedge clk);
    chk("underflow_set", 64'(err_underflow), 64'(1));

    // Reset in the middle of a message from source 2.
    @(posedge clk); #2;
    w0 = words_pushed;
    load_msg(2, 3);
    plan();
    n = 0;
    while (words_pushed < w0 + 1 && n < 100) begin @(posedge clk); n++; end
    #3 reset = 1'b1;
    #1;
    chk("reset_async", 64'({varint_in_fifo_push, req_ready, varint_in_index_push, done_valid,
        busy, err_underflow, varint_in_fifo_data}), 64'(0));
    for (int s = 0; s < NUM_REQ; s++) begin
      src_q[s].delete();
      mdl_q[s].delete();
    end
    exp_word_q.delete();
    exp_tag_q.delete();
    model_last = NUM_REQ - 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #2;
    push_cyc_q.delete();
    load_msg(1, 1);
    load_msg(0, 1);
    plan();
    wait_drain("post_reset");
    chk("post_reset_pushes", 64'(push_cyc_q.size()), 64'(2));
    wait_done("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
